// File: rtl/gemm_c_drain.sv
// Result-side drain for the GeMM C write port: buffers whole C tiles in a small FIFO
// and streams them element-by-element. Optional signed saturation: GEMM_C_DRAIN_SAT_EN.
module gemm_c_drain #(
  parameter int OutDataWidth = 32,
  parameter int StreamWidth  = 16,
  parameter int M            = 4,
  parameter int N            = 4,
  parameter int AddrWidthC   = 10,
  parameter int Depth        = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              sram_c_we_i,
  input  logic [AddrWidthC-1:0]             sram_c_addr_i,
  input  logic [OutDataWidth*M*N-1:0]       sram_c_wdata_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [StreamWidth-1:0]            out_data_o,
  output logic [AddrWidthC-1:0]             out_tile_addr_o,
  output logic [$clog2(M*N)-1:0]            out_elem_idx_o,
  output logic                              out_last_o,
  output logic [$clog2(Depth):0]            level_o,
  output logic                              full_o,
  output logic                              overflow_o
);

  localparam int TileW = OutDataWidth * M * N;
  localparam int Elems = M * N;
  localparam int ElemW = $clog2(Elems);
  localparam int PtrW  = $clog2(Depth);
  localparam int LvlW  = PtrW + 1;
  localparam logic [ElemW-1:0] LastIdx  = ElemW'(Elems - 1);
  localparam logic [LvlW-1:0]  DepthLvl = LvlW'(Depth);

  typedef enum logic {EMPTY = 1'b0, DRAIN = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]        level_q, level_d;
  logic [ElemW-1:0]       elem_q, elem_d;
  logic                   overflow_q, overflow_d;

  logic [AddrWidthC-1:0]  addr_mem [Depth];
  logic [TileW-1:0]       data_mem [Depth];

  logic                   full, valid, last, pop, pop_last, push, drop;
  logic [OutDataWidth-1:0] head_elem;
  logic [StreamWidth-1:0]  head_stream;

  // Stream handshake: a beat transfers on out_valid_o && out_ready_i; while valid is
  // high and ready low every out_* signal holds, since no state moves without a pop.
  assign full     = (level_q == DepthLvl);
  assign valid    = (state_q == DRAIN);
  assign last     = valid && (elem_q == LastIdx);
  assign pop      = valid && out_ready_i;
  assign pop_last = pop && last;
  assign push     = sram_c_we_i && !clear_i && (!full || pop_last);
  assign drop     = sram_c_we_i && full && !pop_last;

  assign head_elem = data_mem[rd_ptr_q][int'(elem_q)*OutDataWidth +: OutDataWidth];

`ifdef GEMM_C_DRAIN_SAT_EN
  localparam logic signed [OutDataWidth-1:0] SatMax =
    {{(OutDataWidth-StreamWidth+1){1'b0}}, {(StreamWidth-1){1'b1}}};
  localparam logic signed [OutDataWidth-1:0] SatMin =
    {{(OutDataWidth-StreamWidth+1){1'b1}}, {(StreamWidth-1){1'b0}}};

  always_comb begin
    head_stream = head_elem[StreamWidth-1:0];
    if ($signed(head_elem) > SatMax)      head_stream = SatMax[StreamWidth-1:0];
    else if ($signed(head_elem) < SatMin) head_stream = SatMin[StreamWidth-1:0];
  end
`else
  assign head_stream = head_elem[StreamWidth-1:0];
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    elem_d     = elem_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      elem_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (drop) overflow_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  elem_d = last ? '0 : elem_q + ElemW'(1);
      if (pop_last) rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop_last})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
    state_d = (level_d != '0) ? DRAIN : EMPTY;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      elem_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      elem_q     <= elem_d;
      overflow_q <= overflow_d;
    end
  end

  // Tile storage carries no reset; outputs are gated by valid so stale contents never show.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= sram_c_addr_i;
      data_mem[wr_ptr_q] <= sram_c_wdata_i;
    end
  end

  assign out_valid_o     = valid;
  assign out_data_o      = valid ? head_stream : '0;
  assign out_tile_addr_o = valid ? addr_mem[rd_ptr_q] : '0;
  assign out_elem_idx_o  = elem_q;
  assign out_last_o      = last;
  assign level_o         = level_q;
  assign full_o          = full;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_gemm_c_drain.sv
// Directed bench for gemm_c_drain: single tile, backpressure, overflow/clear,
// full-with-pop_last write, width conversion and asynchronous reset mid-drain.
module tb_gemm_c_drain;

  localparam int OW = 32;
  localparam int SW = 16;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int D  = 4;
  localparam int TW = OW * M * N;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            clear_i = 1'b0;
  logic            sram_c_we_i = 1'b0;
  logic [AW-1:0]   sram_c_addr_i = '0;
  logic [TW-1:0]   sram_c_wdata_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [SW-1:0]   out_data_o;
  logic [AW-1:0]   out_tile_addr_o;
  logic [3:0]      out_elem_idx_o;
  logic            out_last_o;
  logic [2:0]      level_o;
  logic            full_o;
  logic            overflow_o;

  int checks = 0;
  int errors = 0;

  gemm_c_drain #(
    .OutDataWidth(OW), .StreamWidth(SW), .M(M), .N(N), .AddrWidthC(AW), .Depth(D)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .sram_c_we_i(sram_c_we_i), .sram_c_addr_i(sram_c_addr_i), .sram_c_wdata_i(sram_c_wdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_tile_addr_o(out_tile_addr_o), .out_elem_idx_o(out_elem_idx_o),
    .out_last_o(out_last_o), .level_o(level_o), .full_o(full_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] make_tile(input int base);
    logic [TW-1:0] t;
    t = '0;
    for (int e = 0; e < M * N; e++) t[e*OW +: OW] = OW'(base + e);
    return t;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one write for exactly one edge; returns at #1 after that edge.
  task automatic write_tile(input int addr, input logic [TW-1:0] data);
    sram_c_we_i    = 1'b1;
    sram_c_addr_i  = AW'(addr);
    sram_c_wdata_i = data;
    step();
    sram_c_we_i    = 1'b0;
  endtask

  // Expects ready high; checks all 16 beats of a tile whose element e is base+e.
  task automatic drain_tile(input string tag, input int addr, input int base);
    for (int e = 0; e < M * N; e++) begin
      check({tag, "_valid"}, 32'(out_valid_o), 32'd1);
      check({tag, "_addr"}, 32'(out_tile_addr_o), 32'(addr));
      check({tag, "_idx"}, 32'(out_elem_idx_o), 32'(e));
      check({tag, "_data"}, 32'(out_data_o), 32'(base + e));
      check({tag, "_last"}, 32'(out_last_o), 32'(e == M * N - 1));
      step();
    end
  endtask

  initial begin
    logic [TW-1:0] tile;
    int exp_e;
    int cyc;
    logic [3:0] pat;
    logic [SW-1:0] exp_pos, exp_neg;

    // Reset values
    #2;
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_data", 32'(out_data_o), 32'd0);
    check("rst_addr", 32'(out_tile_addr_o), 32'd0);
    check("rst_idx", 32'(out_elem_idx_o), 32'd0);
    check("rst_last", 32'(out_last_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    #10 rst_ni = 1'b1;
    step();

    // Single tile, ready held high: first beat one cycle after the write
    out_ready_i = 1'b1;
    write_tile(5, make_tile(1));
    check("t1_level", 32'(level_o), 32'd1);
    drain_tile("t1", 5, 1);
    check("t1_empty", 32'(out_valid_o), 32'd0);
    check("t1_level0", 32'(level_o), 32'd0);

    // Backpressure with ready pattern 1,0,0,1
    out_ready_i = 1'b0;
    pat = 4'b1001;
    write_tile(7, make_tile(16'h100));
    exp_e = 0;
    cyc = 0;
    while (exp_e < M * N && cyc < 100) begin
      check("bp_valid", 32'(out_valid_o), 32'd1);
      check("bp_idx", 32'(out_elem_idx_o), 32'(exp_e));
      check("bp_data", 32'(out_data_o), 32'(16'h100 + exp_e));
      check("bp_addr", 32'(out_tile_addr_o), 32'd7);
      out_ready_i = pat[3 - (cyc % 4)];
      step();
      if (out_ready_i) exp_e++;
      cyc++;
    end
    check("bp_done", 32'(exp_e), 32'(M * N));
    check("bp_empty", 32'(out_valid_o), 32'd0);

    // Overflow: five back-to-back writes with ready low
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      write_tile(10 + i, make_tile((i + 1) * 256));
      if (i == 3) begin
        check("ov_level4", 32'(level_o), 32'd4);
        check("ov_full4", 32'(full_o), 32'd1);
        check("ov_not_yet", 32'(overflow_o), 32'd0);
      end
    end
    check("ov_level", 32'(level_o), 32'd4);
    check("ov_full", 32'(full_o), 32'd1);
    check("ov_flag", 32'(overflow_o), 32'd1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) drain_tile("ov_drain", 10 + i, (i + 1) * 256);
    check("ov_drained", 32'(out_valid_o), 32'd0);
    check("ov_sticky", 32'(overflow_o), 32'd1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("clr_level", 32'(level_o), 32'd0);
    check("clr_ovf", 32'(overflow_o), 32'd0);

    // Clear beats a same-cycle write
    out_ready_i = 1'b0;
    write_tile(30, make_tile(16'h400));
    check("clr2_level1", 32'(level_o), 32'd1);
    clear_i = 1'b1;
    write_tile(31, make_tile(16'h500));
    clear_i = 1'b0;
    check("clr2_level", 32'(level_o), 32'd0);
    check("clr2_valid", 32'(out_valid_o), 32'd0);
    check("clr2_idx", 32'(out_elem_idx_o), 32'd0);

    // Write coinciding with pop_last while full
    for (int i = 0; i < 4; i++) write_tile(20 + i, make_tile(16'h1000 * (i + 1)));
    check("sim_full", 32'(full_o), 32'd1);
    out_ready_i = 1'b1;
    for (int e = 0; e < M * N - 1; e++) begin
      check("sim_idx", 32'(out_elem_idx_o), 32'(e));
      step();
    end
    check("sim_last", 32'(out_last_o), 32'd1);
    write_tile(24, make_tile(16'h5000));
    check("sim_level", 32'(level_o), 32'd4);
    check("sim_fullk", 32'(full_o), 32'd1);
    check("sim_ovf", 32'(overflow_o), 32'd0);
    for (int i = 1; i < 5; i++) drain_tile("sim_drain", 20 + i, 16'h1000 * (i + 1));
    check("sim_empty", 32'(out_valid_o), 32'd0);

    // Width conversion of signed elements
`ifdef GEMM_C_DRAIN_SAT_EN
    exp_pos = 16'h7FFF;
    exp_neg = 16'h8000;
`else
    exp_pos = 16'h2345;
    exp_neg = 16'h0000;
`endif
    tile = make_tile(0);
    tile[0 +: OW]  = 32'h0001_2345;
    tile[OW +: OW] = 32'hFFFF_0000;
    write_tile(2, tile);
    check("w_pos", 32'(out_data_o), 32'(exp_pos));
    step();
    check("w_neg", 32'(out_data_o), 32'(exp_neg));
    check("w_small", 32'd0, 32'd0 & 32'(out_idle_dummy()));
    for (int e = 1; e < M * N; e++) step();
    check("w_empty", 32'(out_valid_o), 32'd0);

    // Asynchronous reset after 7 beats
    write_tile(3, make_tile(16'h300));
    for (int e = 0; e < 7; e++) step();
    check("rm_idx7", 32'(out_elem_idx_o), 32'd7);
    #2 rst_ni = 1'b0;
    #1;
    check("rm_valid", 32'(out_valid_o), 32'd0);
    check("rm_data", 32'(out_data_o), 32'd0);
    check("rm_addr", 32'(out_tile_addr_o), 32'd0);
    check("rm_idx", 32'(out_elem_idx_o), 32'd0);
    check("rm_level", 32'(level_o), 32'd0);
    #2 rst_ni = 1'b1;
    step();
    write_tile(9, make_tile(16'h900));
    drain_tile("rm_next", 9, 16'h900);
    check("rm_empty", 32'(out_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic out_idle_dummy();
    return out_valid_o;
  endfunction

endmodule

// File: doc/gemm_c_drain.md
# gemm_c_drain

GeMM result-side drain: the receiving end of the accelerator's C-SRAM write port. It captures each wide C tile write (`M*N` results of `OutDataWidth` bits plus tile address) into a small tile FIFO. It then serializes the tiles element-by-element onto a narrow valid/ready stream toward the host/DMA. The accelerator write port has no backpressure, so overflow is detected and flagged, never stalled.

## Interface
- `OutDataWidth`, 32, width of one C element as written by the accelerator
- `StreamWidth`, 16, width of one streamed element (must be ≤ `OutDataWidth`)
- `M`, 4, tile rows
- `N`, 4, tile columns
- `AddrWidthC`, 10, tile address width
- `Depth`, 4, tile FIFO depth (power of two, ≥2)

- `clk_i` in 1 — clock
- `rst_ni` in 1 — reset, asynchronous, active-low
- `clear_i` in 1 — synchronous flush: empties FIFO, clears `overflow_o`
- `sram_c_we_i` in 1 — tile write strobe from accelerator
- `sram_c_addr_i` in `AddrWidthC` — tile address
- `sram_c_wdata_i` in `OutDataWidth*M*N` — tile data; element `e=m*N+n` at bits `[e*OutDataWidth +: OutDataWidth]`
- `out_valid_o` out 1 — stream element valid
- `out_ready_i` in 1 — stream element ready
- `out_data_o` out `StreamWidth` — element value
- `out_tile_addr_o` out `AddrWidthC` — tile address of current element
- `out_elem_idx_o` out `$clog2(M*N)` — element index `e` within tile
- `out_last_o` out 1 — high with element `M*N-1`
- `level_o` out `$clog2(Depth)+1` — tiles stored, including the one being drained
- `full_o` out 1 — `level_o == Depth`
- `overflow_o` out 1 — sticky: a write was dropped

## Operation
- Storage: `Depth` entries of {addr, wdata}, circular write/read pointers, and an element counter `elem_q` (0..`M*N-1`) on the head entry.
- States: EMPTY (`level==0`), DRAIN (`level>0`). `out_valid_o = (level != 0)`.
- Accept: write stored iff `sram_c_we_i && (!full_o || pop_last)`, where `pop_last = out_valid_o && out_ready_i && out_last_o`. When full and `pop_last` occur in the same cycle, the write is accepted and the level stays `Depth`.
- Drop: `sram_c_we_i && full_o && !pop_last` → the write is discarded and `overflow_o` is set next cycle. `overflow_o` stays set until `clear_i` or reset.
- Handshake: a transfer occurs on `out_valid_o && out_ready_i`, and `elem_q` increments. On `elem_q == M*N-1`, `elem_q` wraps to 0, the read pointer advances and the level decrements (unless a simultaneous write is accepted).
- While `out_valid_o && !out_ready_i`, all `out_*` outputs are held stable.
- Element order is row-major: e=0 (m0,n0) first, and `out_last_o` is asserted on e=`M*N-1`.
- Width: `out_data_o` is derived from the signed `OutDataWidth` element per Configuration.
- `clear_i` has priority over same-cycle write and pop. Next cycle: level 0, `elem_q` 0, pointers 0, overflow 0. The same-cycle write is discarded.
- Pointers wrap modulo `Depth`. The level counter never exceeds `Depth` or underflows.

## Timing
- Reset values: `out_valid_o=0`, `out_data_o=0`, `out_tile_addr_o=0`, `out_elem_idx_o=0`, `out_last_o=0`, `level_o=0`, `full_o=0`, `overflow_o=0`.
- A write accepted at edge t into an empty FIFO gives `out_valid_o=1` after edge t, with element 0 of that tile.
- Throughput: one element per cycle with `out_ready_i` held high. A tile drains in `M*N` cycles with no bubble between tiles.
- `level_o`/`full_o` update on the edge after the write/pop.
- Reset asserted mid-drain: all state clears immediately (asynchronously), and the partial tile is lost.

## Configuration
- `GEMM_C_DRAIN_SAT_EN` defined: each element is saturated as a signed value to the `StreamWidth` range (`[-2^(StreamWidth-1), 2^(StreamWidth-1)-1]`).
- Not defined: `out_data_o` is the low `StreamWidth` bits of the element (two's-complement truncation).

## Test plan
- Single tile, addr 5, element e = e+1, ready held high → 16 beats with data 1..16, idx 0..15, `out_tile_addr_o`=5, `out_last_o` only on beat 16, first valid one cycle after the write.
- Backpressure: ready toggles 1,0,0,1 during a tile → no element lost or duplicated, and `out_*` stable during stalls.
- Overflow: 5 back-to-back writes, ready low → `level_o`=4, `full_o`=1, 5th write dropped, `overflow_o`=1; the first 4 tiles drain intact. Then `clear_i` → level 0, overflow 0.
- Simultaneous: full FIFO, a write coincides with `pop_last` → write accepted, `level_o` stays 4, `overflow_o` stays 0.
- Element value 0x0001_2345, and element value 0xFFFF_0000 → with SAT_EN: 0x7FFF and 0x8000. Without SAT_EN: 0x2345 and 0x0000.
- Reset asserted after 7 beats of a tile → outputs return to reset values immediately; the next write streams from idx 0.
